// File: rtl/ula_pkg.sv
// Shared types and constants for the ULA command sequencer.
package ula_pkg;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} ula_seq_state_t;

  // Bit positions inside the 4-bit flag register {ovf, eq, carry, zero}.
  localparam int FLG_ZERO  = 0;
  localparam int FLG_CARRY = 1;
  localparam int FLG_EQ    = 2;
  localparam int FLG_OVF   = 3;

  // Register-index-independent part of a command.
  typedef struct packed {
    logic [3:0] s;
    logic       m;
    logic       cin;
    logic       use_carry;
    logic       load;
    logic [7:0] imm;
  } ula_cmd_t;

  // Builds the flag word from the ALU status and result.
  function automatic logic [3:0] pack_flags(input logic ovf, input logic eq,
                                            input logic carry, input logic [7:0] f);
    logic [3:0] fl;
    fl            = '0;
    fl[FLG_OVF]   = ovf;
    fl[FLG_EQ]    = eq;
    fl[FLG_CARRY] = carry;
    fl[FLG_ZERO]  = (f == 8'h00);
    return fl;
  endfunction

endpackage

// File: rtl/ula_exec_sequencer_if.sv
// Command, response and ALU channels of the ULA sequencer.
interface ula_exec_sequencer_if #(parameter int NREGS = 4);

  localparam int AW = $clog2(NREGS);

  // Command channel
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_s;
  logic          cmd_m;
  logic          cmd_cin;
  logic          cmd_use_carry;
  logic          cmd_load;
  logic [7:0]    cmd_imm;
  logic [AW-1:0] cmd_src_a;
  logic [AW-1:0] cmd_src_b;
  logic [AW-1:0] cmd_dst;

  // ALU channel
  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic [3:0]    alu_s;
  logic          alu_m;
  logic          alu_cin;
  logic [7:0]    alu_f;
  logic          alu_c_out;
  logic          alu_a_eq_b;
  logic          alu_overflow;

  // Response channel
  logic          res_valid;
  logic          res_ready;
  logic [7:0]    res_data;
  logic [3:0]    res_flags;

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_s, cmd_m, cmd_cin, cmd_use_carry, cmd_load, cmd_imm,
           cmd_src_a, cmd_src_b, cmd_dst,
    output cmd_ready,
    output alu_a, alu_b, alu_s, alu_m, alu_cin,
    input  alu_f, alu_c_out, alu_a_eq_b, alu_overflow,
    output res_valid, res_data, res_flags,
    input  res_ready
  );

  // Command issuer / ALU / result consumer side.
  modport master (
    output cmd_valid, cmd_s, cmd_m, cmd_cin, cmd_use_carry, cmd_load, cmd_imm,
           cmd_src_a, cmd_src_b, cmd_dst,
    input  cmd_ready,
    input  alu_a, alu_b, alu_s, alu_m, alu_cin,
    output alu_f, alu_c_out, alu_a_eq_b, alu_overflow,
    input  res_valid, res_data, res_flags,
    output res_ready
  );

endinterface

// File: rtl/ula_regfile.sv
// NREGS x 8 register file: two operand read ports, one debug read port,
// one synchronous write port, cleared by reset.
module ula_regfile #(
  parameter int NREGS = 4,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra_addr_i,
  output logic [7:0]    ra_data_o,
  input  logic [AW-1:0] rb_addr_i,
  output logic [7:0]    rb_data_o,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [7:0]    wd_i
);

  logic [7:0] mem_q [NREGS];

  // Storage update: reset wins over a write in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the whole array is cleared on reset because the sequencer
      // promises all-zero registers afterwards; a plain RAM would not be reset.
      for (int i = 0; i < NREGS; i++) mem_q[i] <= 8'h00;
    end else if (we_i) begin
      // NOTE: non-blocking so that reads in the same edge see the old value.
      mem_q[wa_i] <= wd_i;
    end
  end

  assign ra_data_o = mem_q[ra_addr_i];
  assign rb_data_o = mem_q[rb_addr_i];
  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/ula_exec_sequencer.sv
// Command sequencer in front of ula_8_bits: reads operands, drives the ALU
// for one EXEC cycle, writes the result and flags back, returns the result.
module ula_exec_sequencer
  import ula_pkg::*;
#(
  parameter int NREGS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  ula_exec_sequencer_if.slave        io,
  input  logic [$clog2(NREGS)-1:0]   rd_addr,
  output logic [7:0]                 rd_data
);

  localparam int AW = $clog2(NREGS);

  ula_seq_state_t state_q, state_d;
  ula_cmd_t       cmd;

  logic [AW-1:0] dst_q;
  logic [7:0]    alu_a_q, alu_b_q;
  logic [3:0]    alu_s_q;
  logic          alu_m_q, alu_cin_q;
  logic [3:0]    flags_q, flags_d;
  logic [7:0]    res_data_q, res_data_d;

  logic [7:0]    rdata_a, rdata_b;
  logic          cmd_fire;
  logic          cmd_ready_c, res_valid_c;
  logic          we;
  logic [AW-1:0] wa;
  logic [7:0]    wd;

  assign cmd = '{s:         io.cmd_s,
                 m:         io.cmd_m,
                 cin:       io.cmd_cin,
                 use_carry: io.cmd_use_carry,
                 load:      io.cmd_load,
                 imm:       io.cmd_imm};

  ula_regfile #(.NREGS(NREGS), .AW(AW)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .ra_addr_i (io.cmd_src_a),
    .ra_data_o (rdata_a),
    .rb_addr_i (io.cmd_src_b),
    .rb_data_o (rdata_b),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data),
    .we_i      (we),
    .wa_i      (wa),
    .wd_i      (wd)
  );

  // Next state, handshakes, writeback port and result/flag updates.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    cmd_ready_c = 1'b0;
    res_valid_c = 1'b0;
    cmd_fire    = 1'b0;
    we          = 1'b0;
    wa          = dst_q;
    wd          = io.alu_f;
    flags_d     = flags_q;
    res_data_d  = res_data_q;

    case (state_q)
      IDLE: cmd_ready_c = 1'b1;
      EXEC: begin
        we         = 1'b1;
        flags_d    = pack_flags(io.alu_overflow, io.alu_a_eq_b, io.alu_c_out, io.alu_f);
        res_data_d = io.alu_f;
        state_d    = RESP;
      end
      RESP: begin
        res_valid_c = 1'b1;
        cmd_ready_c = io.res_ready;   // fast path: take a new command as the result leaves
        if (io.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cmd_fire = io.cmd_valid & cmd_ready_c;
    if (cmd_fire) begin
      if (cmd.load) begin
        we         = 1'b1;
        wa         = io.cmd_dst;
        wd         = cmd.imm;
        res_data_d = cmd.imm;
        state_d    = RESP;
      end else begin
        state_d = EXEC;
      end
    end
  end

  // State, flags, result and ALU operand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      flags_q    <= 4'h0;
      res_data_q <= 8'h00;
      dst_q      <= '0;
      alu_a_q    <= 8'h00;
      alu_b_q    <= 8'h00;
      alu_s_q    <= 4'h0;
      alu_m_q    <= 1'b0;
      alu_cin_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      flags_q    <= flags_d;
      res_data_q <= res_data_d;
      // Operands are captured at accept, so dst == src writebacks are safe.
      if (cmd_fire && !cmd.load) begin
        dst_q     <= io.cmd_dst;
        alu_a_q   <= rdata_a;
        alu_b_q   <= rdata_b;
        alu_s_q   <= cmd.s;
        alu_m_q   <= cmd.m;
        alu_cin_q <= cmd.use_carry ? flags_q[FLG_CARRY] : cmd.cin;
      end
    end
  end

  assign io.cmd_ready = cmd_ready_c;
  assign io.res_valid = res_valid_c;
  assign io.res_data  = res_data_q;
  assign io.res_flags = flags_q;
  assign io.alu_a     = alu_a_q;
  assign io.alu_b     = alu_b_q;
  assign io.alu_s     = alu_s_q;
  assign io.alu_m     = alu_m_q;
  assign io.alu_cin   = alu_cin_q;

endmodule

// File: doc/ula_exec_sequencer.md
# ula_exec_sequencer

Command sequencer and register file that feeds operands into `ula_8_bits` and writes back its results. Accepts one command per valid/ready handshake and reads two source registers. Drives the ALU with registered operands, then captures `f`, `c_out`, `a_eq_b` and `overflow` into a destination register and a flag register. Returns the result on a valid/ready response channel.

## Interface
- `NREGS`, 4, number of 8-bit registers; power of 2, ≥2; `AW = $clog2(NREGS)`
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, synchronous, active-high
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`
- `cmd_s`  in  4  ALU function select, forwarded to `alu_s`
- `cmd_m`  in  1  ALU mode, forwarded to `alu_m`
- `cmd_cin`  in  1  ALU carry-in, used when `cmd_use_carry=0`
- `cmd_use_carry`  in  1  1: `alu_cin` = stored carry flag (multi-byte chaining)
- `cmd_load`  in  1  1: write `cmd_imm` to dst, ALU bypassed
- `cmd_imm`  in  8  immediate for load
- `cmd_src_a`, `cmd_src_b`, `cmd_dst`  in  AW  register indices
- `alu_a`, `alu_b`  out  8  operands to ALU (registered)
- `alu_s`  out  4  function to ALU (registered)
- `alu_m`  out  1  mode to ALU (registered)
- `alu_cin`  out  1  carry-in to ALU (registered)
- `alu_f`  in  8  ALU result
- `alu_c_out`, `alu_a_eq_b`, `alu_overflow`  in  1 each  ALU status
- `res_valid`  out  1  result available
- `res_ready`  in  1  result consumed when `res_valid & res_ready`
- `res_data`  out  8  value written to dst
- `res_flags`  out  4  `{ovf, eq, carry, zero}` after the command
- `rd_addr`  in  AW  debug read index
- `rd_data`  out  8  combinational read of `regs[rd_addr]`

## Operation
- FSM states and transitions:
  - IDLE: `cmd_ready=1`. On accept, latch the command. ALU op → EXEC. Load → RESP.
  - EXEC: `alu_*` hold `regs[src_a]`, `regs[src_b]`, `s`, `m` and cin, registered at accept. At the end of the cycle:
    - `regs[dst] <= alu_f`
    - flags <= `{alu_overflow, alu_a_eq_b, alu_c_out, alu_f==0}`
    - `res_data <= alu_f`
    - → RESP.
  - Load path: `regs[dst] <= cmd_imm` and `res_data <= cmd_imm` at accept; flags unchanged.
  - RESP: `res_valid=1`. `res_data` and `res_flags` stay stable until `res_ready`.
    - `res_ready` and no new command → IDLE.
  - RESP fast path: `cmd_ready = res_ready`. A command accepted in the same cycle as the result is consumed goes straight to EXEC (or RESP for a load).
- Carry polarity is passed through unchanged. The stored carry is raw `alu_c_out`, so chaining is polarity-consistent.
- `src_a == src_b` is allowed. `dst == src` is allowed: writeback occurs after operands are registered.
- A command sees all earlier writebacks: there is no hazard because only one command is in flight.
- `alu_*` outputs hold their last value outside EXEC.

## Timing
- Reset values:
  - state IDLE; `cmd_ready=1`, `res_valid=0`
  - all `regs` = 0x00, flags = 0000, `res_data` = 0x00
  - `alu_a = alu_b = 0x00`, `alu_s = 0000`, `alu_m = 0`, `alu_cin = 0`
- ALU op latency: accept at cycle T, EXEC at T+1, `res_valid` at T+2. Peak throughput is 1 op / 2 cycles using the fast path.
- Load latency: accept at T, `res_valid` at T+1.
- `rd_data` reflects a writeback on the cycle after the write edge.
- `rst` in any state:
  - the in-flight command is dropped and dst is not written
  - `res_valid` is 0 next cycle
  - all registers and flags are cleared
- `cmd_valid` while `cmd_ready=0`: ignored; no latching.

## Structure
- Package `ula_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, EXEC, RESP} ula_seq_state_t`
  - flag bit indices `FLG_ZERO=0`, `FLG_CARRY=1`, `FLG_EQ=2`, `FLG_OVF=3`
  - a packed command struct
- Sub-module `ula_regfile`:
  - NREGS×8 storage, two read ports (src_a, src_b), one debug read port, one synchronous write port
  - reset clears all entries
- Top-level integration wires `alu_*` directly to `ula_8_bits`.

## Test plan
- Reset: hold `rst` for 2 cycles, then release → `cmd_ready=1`, `res_valid=0`, `rd_data=0x00` for every `rd_addr`, `res_flags=0000`.
- Load: load r1=0x3C, then r2=0x0F → `res_data=0x3C` at T+1, then 0x0F; `rd_data(1)=0x3C`; flags unchanged.
- Logic op: with `ula_8_bits` attached, `m=1`, `s=0110` (XOR):
  - r3 = r1^r2 → `res_data=0x33` at T+2, `zero=0`, `eq=0`
  - then r0 = r1^r1 → `res_data=0x00`, `zero=1`, `eq=1`
- Backpressure: hold `res_ready=0` for 5 cycles with `cmd_valid=1` → `res_data` and `res_flags` stable, `cmd_ready=0`, no register changes. Raise `res_ready` → the pending command is accepted in that cycle and its EXEC follows next cycle.
- Carry chaining: run an op with `alu_c_out=1`, then send a command with `cmd_use_carry=1`, `cmd_cin=0` → `alu_cin=1` during its EXEC. With `cmd_use_carry=0`, `alu_cin` equals `cmd_cin`.
- Reset mid-op: assert `rst` during EXEC of r3=r1^r2 → r3 stays 0x00 (all regs 0), `res_valid` never rises, `cmd_ready=1` the cycle after release.
